// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Encodes symbolic instruction requests into 32-bit instruction words using
// the datapath opcode map and writes them, one after another, into the
// instruction memory through a synchronous write port.  The boot path and
// the bench use it to load a program before the datapath leaves reset.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// The op fields are sampled only on that edge.  The source must hold the
// request stable while req_valid is high and req_ready is low.
//
// Optional feature macro: LOADER_VERIFY_EN
//   When defined, every written word is read back (VERIFY_RD) and compared
//   (VERIFY_CMP) before the next request is taken; a mismatch sets the
//   sticky verify_err.  When undefined, imem_re and verify_err are tied 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   op_sel                0 R, 1 LW, 2 SW, 3 BEQ, 4 BMN, 5 BZ, 6 JALM, 7 J,
//                         8-15 illegal
//   rs, rt, rd, shamt,
//   funct, imm16,
//   target26              instruction fields
//   imem_we/addr/wdata    instruction memory write port
//   imem_re/rdata         instruction memory read port (verify only)
//   count, full           words written, count == DEPTH
//   illegal_err           sticky: an illegal op_sel was accepted
//   verify_err            sticky: readback mismatch
//   dbg_state             current FSM state (0 IDLE, 1 WRITE,
//                         2 VERIFY_RD, 3 VERIFY_CMP)
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int unsigned           ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
    parameter int unsigned           DEPTH     = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [3:0]                   op_sel,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   shamt,
    input  logic [5:0]                   funct,
    input  logic [15:0]                  imm16,
    input  logic [25:0]                  target26,
    output logic                         imem_we,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic                         imem_re,
    input  logic [31:0]                  imem_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         illegal_err,
    output logic                         verify_err,
    output logic [1:0]                   dbg_state
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1
`ifdef LOADER_VERIFY_EN
        ,
        ST_VERIFY_RD  = 2'd2,
        ST_VERIFY_CMP = 2'd3
`endif
    } state_t;

    state_t              state_q;
    logic                req_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [CNT_W-1:0]    count_q;
    logic                full_q;
    logic                illegal_q;

    logic                enc_legal;
    logic [31:0]         enc_word;
    logic                accept;
    logic                last_word;

    // Combinational packing of the request fields; only the fields the
    // selected format uses reach the word.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'h0;
        case (op_sel)
            4'd0: enc_word = {6'b000000, rs, rt, rd, shamt, funct};
            4'd1: enc_word = {6'b100011, rs, rt, imm16};
            4'd2: enc_word = {6'b101011, rs, rt, imm16};
            4'd3: enc_word = {6'b000100, rs, rt, imm16};
            4'd4: enc_word = {6'b010101, rs, rt, imm16};
            4'd5: enc_word = {6'b011000, target26};
            4'd6: enc_word = {6'b010011, rs, rt, imm16};
            4'd7: enc_word = {6'b000010, target26};
            default: enc_legal = 1'b0;
        endcase
    end

    assign accept    = req_valid && req_ready_q;
    // The word being committed is the one that makes the memory full.
    assign last_word = (count_q == CNT_W'(DEPTH - 1));

`ifdef LOADER_VERIFY_EN
    logic imem_re_q;
    logic verify_q;
`else
    // Read data only matters for the readback check.
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            imem_we_q   <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'h0;
            count_q     <= '0;
            full_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef LOADER_VERIFY_EN
            imem_re_q   <= 1'b0;
            verify_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (enc_legal) begin
                            wdata_q     <= enc_word;
                            imem_we_q   <= 1'b1;
                            req_ready_q <= 1'b0;
                            state_q     <= ST_WRITE;
                        end else begin
                            // Illegal requests are consumed without a write.
                            illegal_q   <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    imem_we_q <= 1'b0;
`ifdef LOADER_VERIFY_EN
                    // addr_q still holds the just-written address.
                    imem_re_q <= 1'b1;
                    state_q   <= ST_VERIFY_RD;
`else
                    count_q     <= count_q + 1'b1;
                    addr_q      <= addr_q + ADDR_W'(4);
                    full_q      <= last_word;
                    req_ready_q <= !last_word;
                    state_q     <= ST_IDLE;
`endif
                end
`ifdef LOADER_VERIFY_EN
                ST_VERIFY_RD: begin
                    imem_re_q <= 1'b0;
                    state_q   <= ST_VERIFY_CMP;
                end
                ST_VERIFY_CMP: begin
                    // Read data for the strobe of the previous cycle.
                    if (imem_rdata != wdata_q) begin
                        verify_q <= 1'b1;
                    end
                    count_q     <= count_q + 1'b1;
                    addr_q      <= addr_q + ADDR_W'(4);
                    full_q      <= last_word;
                    req_ready_q <= !last_word;
                    state_q     <= ST_IDLE;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign full        = full_q;
    assign illegal_err = illegal_q;
    assign dbg_state   = state_q;
`ifdef LOADER_VERIFY_EN
    assign imem_re     = imem_re_q;
    assign verify_err  = verify_q;
`else
    assign imem_re     = 1'b0;
    assign verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef LOADER_VERIFY_EN
  localparam int WORD_CYC = 4;
`else
  localparam int WORD_CYC = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  op_sel = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_re;
  logic [31:0] imem_rdata = '0;
  logic [2:0]  count;
  logic        full;
  logic        illegal_err;
  logic        verify_err;
  logic [1:0]  dbg_state;

  instr_encoder_loader #(
    .ADDR_W(32),
    .BASE_ADDR(BASE),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .target26(target26),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_re(imem_re), .imem_rdata(imem_rdata),
    .count(count), .full(full), .illegal_err(illegal_err),
    .verify_err(verify_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  // Readback of byte address 0x4 comes back with bit 0 flipped.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (!reset && imem_we) mem[imem_addr[7:2]] <= imem_wdata;
    if (imem_re) imem_rdata <= mem[imem_addr[7:2]] ^ ((imem_addr == 32'h4) ? 32'h1 : 32'h0);
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr = BASE;
  logic [31:0] cur_exp = '0;
  bit          cur_legal = 1'b0;
  int          n_acc = 0;
  int          n_wr = 0;
  int          wr_cyc_q[$];
  logic [31:0] last_wr_addr = '0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_addr = BASE;
    end else if (req_valid && req_ready) begin
      n_acc++;
      if (cur_legal) begin
        exp_q.push_back({exp_addr, cur_exp});
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      n_wr++;
      wr_cyc_q.push_back(cyc);
      last_wr_addr = imem_addr;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {32'h0, imem_addr}, 64'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {32'h0, imem_addr}, {32'h0, e[63:32]});
        chk("wr_data", {32'h0, imem_wdata}, {32'h0, e[31:0]});
      end
    end
    if (!reset && imem_re) begin
`ifdef LOADER_VERIFY_EN
      chk("re_addr", {32'h0, imem_addr}, {32'h0, last_wr_addr});
      chk("re_we_overlap", {63'h0, imem_we}, 64'h0);
`else
      chk("re_tied_low", {63'h0, imem_re}, 64'h0);
`endif
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp_word;
    bit          rst_before;
    int          exp_count;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply_fields(input vec_t v);
    op_sel = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt;
    funct = v.funct; imm16 = v.imm; target26 = v.tgt;
  endtask

  task automatic send(input vec_t v, input bit legal);
    int waited;
    @(negedge clk);
    apply_fields(v);
    cur_exp = v.exp_word;
    cur_legal = legal;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'h0, 64'h1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("we_latency", {63'h0, imem_we}, {63'h0, legal});
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || dbg_state != 2'd0) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0 || dbg_state != 2'd0) chk("drain_timeout", 64'h0, 64'h1);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h0022_1820, 1'b1, 1};
    vecs[1] = '{4'd1, 5'd2, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0, 32'h8C45_0010, 1'b1, 1};
    vecs[2] = '{4'd2, 5'd2, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 32'hAC45_0004, 1'b0, 2};
    vecs[3] = '{4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 32'h1022_FFFF, 1'b0, 3};
    vecs[4] = '{4'd4, 5'd3, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0, 32'h5460_0008, 1'b1, 1};
    vecs[5] = '{4'd6, 5'd4, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0000, 26'h0, 32'h4C9F_0000, 1'b0, 2};
    vecs[6] = '{4'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 32'h6000_0010, 1'b0, 3};
    vecs[7] = '{4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h40, 32'h0800_0040, 1'b0, 4};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_ready", {63'h0, req_ready}, 64'h1);
    chk("rst_we", {63'h0, imem_we}, 64'h0);
    chk("rst_re", {63'h0, imem_re}, 64'h0);
    chk("rst_addr", {32'h0, imem_addr}, {32'h0, BASE});
    chk("rst_wdata", {32'h0, imem_wdata}, 64'h0);
    chk("rst_count", {61'h0, count}, 64'h0);
    chk("rst_full", {63'h0, full}, 64'h0);
    chk("rst_illegal", {63'h0, illegal_err}, 64'h0);
    chk("rst_verify", {63'h0, verify_err}, 64'h0);
    chk("rst_state", {62'h0, dbg_state}, 64'h0);

    // Encoding table; fields the format ignores carry random junk.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.op == 4'd0) begin
        v.imm = 16'($urandom_range(0, 65535));
        v.tgt = 26'($urandom);
      end else if (v.op == 4'd5 || v.op == 4'd7) begin
        v.rs = 5'($urandom_range(0, 31)); v.rt = 5'($urandom_range(0, 31));
        v.rd = 5'($urandom_range(0, 31)); v.shamt = 5'($urandom_range(0, 31));
        v.funct = 6'($urandom_range(0, 63)); v.imm = 16'($urandom_range(0, 65535));
      end else begin
        v.rd = 5'($urandom_range(0, 31)); v.shamt = 5'($urandom_range(0, 31));
        v.funct = 6'($urandom_range(0, 63)); v.tgt = 26'($urandom);
      end
      if (v.rst_before) do_reset();
      send(v, 1'b1);
      drain();
      chk("tbl_count", {61'h0, count}, 64'(v.exp_count));
      chk("tbl_addr", {32'h0, imem_addr}, {32'h0, BASE + 32'(4 * v.exp_count)});
      chk("tbl_full", {63'h0, full}, {63'h0, (v.exp_count == DEPTH)});
    end

    // Valid held high with 5+ requests offered: only DEPTH are taken.
    begin
      int acc0, wr0;
      do_reset();
      acc0 = n_acc;
      wr0 = n_wr;
      wr_cyc_q.delete();
      @(negedge clk);
      apply_fields(vecs[1]);
      cur_exp = vecs[1].exp_word;
      cur_legal = 1'b1;
      req_valid = 1'b1;
      repeat (40) @(negedge clk);
      chk("full_accepts", 64'(n_acc - acc0), 64'(DEPTH));
      chk("full_writes", 64'(n_wr - wr0), 64'(DEPTH));
      chk("full_count", {61'h0, count}, 64'(DEPTH));
      chk("full_flag", {63'h0, full}, 64'h1);
      chk("full_ready", {63'h0, req_ready}, 64'h0);
      chk("full_addr", {32'h0, imem_addr}, {32'h0, BASE + 32'(4 * DEPTH)});
      chk("full_pending", 64'(exp_q.size()), 64'h0);
      if (wr_cyc_q.size() == DEPTH)
        chk("throughput", 64'(wr_cyc_q[DEPTH-1] - wr_cyc_q[0]), 64'((DEPTH - 1) * WORD_CYC));
      else
        chk("throughput_samples", 64'(wr_cyc_q.size()), 64'(DEPTH));
      req_valid = 1'b0;
    end

    // Illegal op, then reset during a WRITE cycle.
    begin
      vec_t bad;
      int wr0;
      do_reset();
      bad = vecs[1];
      bad.op = 4'd9;
      wr0 = n_wr;
      send(bad, 1'b0);
      chk("ill_err", {63'h0, illegal_err}, 64'h1);
      chk("ill_ready", {63'h0, req_ready}, 64'h1);
      chk("ill_count", {61'h0, count}, 64'h0);
      chk("ill_state", {62'h0, dbg_state}, 64'h0);
      chk("ill_nowrite", 64'(n_wr - wr0), 64'h0);
      send(vecs[0], 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rstw_we", {63'h0, imem_we}, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rstw_count", {61'h0, count}, 64'h0);
      chk("rstw_addr", {32'h0, imem_addr}, {32'h0, BASE});
      chk("rstw_illegal", {63'h0, illegal_err}, 64'h0);
      chk("rstw_ready", {63'h0, req_ready}, 64'h1);
      chk("rstw_nowrite", 64'(n_wr - wr0), 64'h0);
    end

    // Readback check: word at 0x0 reads clean, word at 0x4 is corrupted.
    do_reset();
    send(vecs[1], 1'b1);
    drain();
    chk("verify_first", {63'h0, verify_err}, 64'h0);
    send(vecs[2], 1'b1);
    drain();
`ifdef LOADER_VERIFY_EN
    chk("verify_second", {63'h0, verify_err}, 64'h1);
`else
    chk("verify_second", {63'h0, verify_err}, 64'h0);
`endif
    chk("verify_count", {61'h0, count}, 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
